// File: rtl/trace_capture_buffer.sv
// Circular trace buffer for committed-instruction records with a PC-match trigger,
// a post-trigger window and an oldest-first valid/ready drain port.
`timescale 1ns/1ps
module trace_capture_buffer #(
    parameter int XLEN      = 64,
    parameter int DEPTH     = 16,
    parameter int CTRL_W    = 9,
    parameter int POST_TRIG = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cap_valid,
    input  logic [XLEN-1:0]              pc_in,
    input  logic [31:0]                  instr_in,
    input  logic [XLEN-1:0]              valE_in,
    input  logic [CTRL_W-1:0]            ctrl_in,
    input  logic                         arm,
    input  logic                         trig_en,
    input  logic [XLEN-1:0]              trig_pc,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [2*XLEN+32+CTRL_W-1:0]  rd_data,
    output logic                         rd_last,
    output logic [1:0]                   state_out,
    output logic [$clog2(DEPTH):0]       count_out
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = 2*XLEN + 32 + CTRL_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic               wr_en_s;
    logic [AW-1:0]      rd_ptr_s;
    logic [REC_W-1:0]   mem [DEPTH];

    // State and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
        end
    end

    // Record storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_q] <= {pc_in, instr_in, valE_in, ctrl_in};
        end
    end

    // Next-state, capture and drain bookkeeping.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        wr_en_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d  = S_ARMED;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ARMED, S_POST: begin
                if (cap_valid) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    // Saturate at DEPTH: beyond that the oldest record is overwritten.
                    if (count_q == CW'(DEPTH)) begin
                        count_d = count_q;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                    if (state_q == S_POST) begin
                        post_cnt_d = post_cnt_q - AW'(1);
                        if (post_cnt_q == AW'(1)) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_POST;
                        end
                    end else if (trig_en && (pc_in == trig_pc)) begin
                        post_cnt_d = AW'(POST_TRIG);
                        state_d    = (POST_TRIG == 0) ? S_DRAIN : S_POST;
                    end else begin
                        state_d = S_ARMED;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DRAIN: begin
                if (rd_ready) begin
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Drain port. wr_ptr is frozen in DRAIN, so wr_ptr - count always names the oldest record.
    always_comb begin
        rd_ptr_s  = wr_ptr_q - count_q[AW-1:0];
        rd_valid  = (state_q == S_DRAIN);
        state_out = state_q;
        count_out = count_q;
        if (state_q == S_DRAIN) begin
            rd_data = mem[rd_ptr_s];
            rd_last = (count_q == CW'(1));
        end else begin
            rd_data = '0;
            rd_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference of the captured window.
`timescale 1ns/1ps
module tb_trace_capture_buffer;
    localparam int XLEN   = 64;
    localparam int DEPTH  = 16;
    localparam int CTRL_W = 9;
    localparam int POSTN  = 8;
    localparam int REC_W  = 2*XLEN + 32 + CTRL_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               cap_valid;
    logic [XLEN-1:0]    pc_in;
    logic [31:0]        instr_in;
    logic [XLEN-1:0]    valE_in;
    logic [CTRL_W-1:0]  ctrl_in;
    logic               arm;
    logic               trig_en;
    logic [XLEN-1:0]    trig_pc;
    logic               rd_ready;
    logic               rd_valid, rd_last;
    logic [REC_W-1:0]   rd_data;
    logic [1:0]         state_out;
    logic [4:0]         count_out;
    logic               rd_valid0, rd_last0;
    logic [REC_W-1:0]   rd_data0;
    logic [1:0]         state_out0;
    logic [4:0]         count_out0;

    int checks   = 0;
    int failures = 0;

    // Reference: window held as a queue, oldest at index 0.
    int                 m_state;
    int                 m_post;
    logic [REC_W-1:0]   m_q[$];

    trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CTRL_W(CTRL_W), .POST_TRIG(POSTN)) dut (
        .clk(clk), .reset(reset), .cap_valid(cap_valid), .pc_in(pc_in), .instr_in(instr_in),
        .valE_in(valE_in), .ctrl_in(ctrl_in), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .state_out(state_out), .count_out(count_out)
    );

    trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CTRL_W(CTRL_W), .POST_TRIG(0)) dut0 (
        .clk(clk), .reset(reset), .cap_valid(cap_valid), .pc_in(pc_in), .instr_in(instr_in),
        .valE_in(valE_in), .ctrl_in(ctrl_in), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0), .rd_last(rd_last0),
        .state_out(state_out0), .count_out(count_out0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_post  = 0;
        m_q.delete();
    endtask

    task automatic model_push();
        m_q.push_back({pc_in, instr_in, valE_in, ctrl_in});
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
    endtask

    task automatic model_edge();
        case (m_state)
            0: if (arm) begin m_q.delete(); m_state = 1; end
            1: if (cap_valid) begin
                model_push();
                if (trig_en && pc_in == trig_pc) begin
                    m_post  = POSTN;
                    m_state = (POSTN == 0) ? 3 : 2;
                end
            end
            2: if (cap_valid) begin
                model_push();
                m_post--;
                if (m_post == 0) m_state = 3;
            end
            default: if (rd_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_state = 0;
            end
        endcase
    endtask

    task automatic check_all();
        logic v;
        v = (m_state == 3);
        chk("state", REC_W'(state_out), REC_W'(m_state));
        chk("count", REC_W'(count_out), REC_W'(m_q.size()));
        chk("rd_valid", REC_W'(rd_valid), REC_W'(v));
        chk("rd_last", REC_W'(rd_last), REC_W'(v && m_q.size() == 1));
        chk("rd_data", rd_data, v ? m_q[0] : '0);
    endtask

    task automatic step(input logic cap, input logic [XLEN-1:0] pc, input logic a,
                        input logic te, input logic [XLEN-1:0] tpc, input logic rdy);
        @(negedge clk);
        cap_valid = cap;
        pc_in     = pc;
        instr_in  = $urandom;
        valE_in   = {$urandom, $urandom};
        ctrl_in   = CTRL_W'($urandom);
        arm       = a;
        trig_en   = te;
        trig_pc   = tpc;
        rd_ready  = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_capture(input logic [XLEN-1:0] tpc, input int entry_k, input int exp_cnt);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, XLEN'(4*k), 1'b0, 1'b1, tpc, 1'b0);
            if (k == entry_k - 1) chk("pre_entry_state", REC_W'(state_out), REC_W'(2));
            if (k == entry_k) begin
                chk("entry_state", REC_W'(state_out), REC_W'(3));
                chk("entry_count", REC_W'(count_out), REC_W'(exp_cnt));
            end
        end
    endtask

    // mode 0: always ready, 1: fixed stall pattern, 2: random
    task automatic drain(input int mode, input logic [XLEN-1:0] first, input int n);
        int hs;
        int pat[6];
        logic rdy;
        logic [XLEN-1:0] obs_pc;
        logic obs_last;
        pat = '{1, 0, 0, 1, 0, 1};
        hs = 0;
        for (int i = 0; i < 300 && m_state == 3; i++) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[i % 6][0] : 1'($urandom);
            obs_pc   = rd_data[REC_W-1 -: XLEN];
            obs_last = rd_last;
            step(1'b0, '0, 1'b0, 1'b0, '0, rdy);
            if (rdy) begin
                chk("drain_pc", REC_W'(obs_pc), REC_W'(first + XLEN'(4*hs)));
                chk("drain_last", REC_W'(obs_last), REC_W'(hs == n - 1));
                hs++;
            end
        end
        chk("drain_handshakes", REC_W'(hs), REC_W'(n));
        chk("drain_idle", REC_W'(state_out), REC_W'(0));
    endtask

    initial begin
        reset = 1'b0; cap_valid = 1'b0; pc_in = '0; instr_in = '0; valE_in = '0; ctrl_in = '0;
        arm = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all();
        reset = 1'b1;

        // 1: trigger at pc 0x50, window 0x34..0x70
        run_capture(64'h50, 28, 16);
        drain(0, 64'h34, 16);
        // 2: early trigger, partial window
        run_capture(64'h8, 10, 11);
        drain(0, 64'h0, 11);
        // 4: stalled drain
        run_capture(64'h50, 28, 16);
        drain(1, 64'h34, 16);

        // 5: reset in POST, then a clean repeat of test 1
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 24; k++) step(1'b1, XLEN'(4*k), 1'b0, 1'b1, 64'h50, 1'b0);
        chk("t5_in_post", REC_W'(state_out), REC_W'(2));
        reset = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_state", REC_W'(state_out), REC_W'(0));
        chk("t5_rst_count", REC_W'(count_out), REC_W'(0));
        chk("t5_rst_valid", REC_W'(rd_valid), REC_W'(0));
        @(negedge clk);
        reset = 1'b1;
        run_capture(64'h50, 28, 16);
        drain(0, 64'h34, 16);

        // 6: no trigger, gaps, re-arm ignored; then trigger and inspect contents
        begin
            int j;
            j = 0;
            step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
            for (int i = 0; i < 200 && j < 40; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    step(1'b0, {32'hdead0000, $urandom}, 1'($urandom), 1'b0, '0, 1'b0);
                end else begin
                    step(1'b1, XLEN'(64'h1000 + 4*j), 1'($urandom), 1'b0, '0, 1'b0);
                    j++;
                end
            end
            chk("t6_armed", REC_W'(state_out), REC_W'(1));
            chk("t6_sat", REC_W'(count_out), REC_W'(16));
            for (int i = 0; i < 60 && m_state != 3; i++) begin
                if (i % 3 == 1) begin
                    step(1'b0, {32'hdead0000, $urandom}, 1'b1, 1'b1, 64'h10a0, 1'b0);
                end else begin
                    step(1'b1, XLEN'(64'h1000 + 4*j), 1'b0, 1'b1, 64'h10a0, 1'b0);
                    j++;
                end
            end
            drain(2, 64'h1000 + 64'd132, 16);
        end

        // 3: POST_TRIG=0 instance, trigger at k=5
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, XLEN'(4*k), 1'b0, 1'b1, 64'h14, 1'b0);
        chk("t3_state", REC_W'(state_out0), REC_W'(3));
        chk("t3_count", REC_W'(count_out0), REC_W'(6));
        for (int i = 0; i < 6; i++) begin
            chk("t3_pc", REC_W'(rd_data0[REC_W-1 -: XLEN]), REC_W'(4*i));
            chk("t3_last", REC_W'(rd_last0), REC_W'(i == 5));
            step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        chk("t3_idle", REC_W'(state_out0), REC_W'(0));
        chk("t3_valid_low", REC_W'(rd_valid0), REC_W'(0));
        do_reset();

        // Randomized traffic against the reference
        for (int r = 0; r < 4; r++) begin
            step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
            for (int i = 0; i < 150; i++) begin
                step(1'($urandom), XLEN'({$urandom_range(0, 15), 2'b00}), ($urandom % 8) == 0,
                     ($urandom % 4) != 0, 64'h20, 1'($urandom));
            end
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
